// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback slice: function codes,
// FSM state encoding and the default datapath width.
package alu_pkg;

  localparam int unsigned SIZE_DEFAULT = 32;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_AND = 3'd2;
  localparam logic [2:0] FN_OR  = 3'd3;
  localparam logic [2:0] FN_NOR = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// entry 0 hardwired to zero, synchronous active-low clear of all entries.
module alu_regfile #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage in front of a combinational ALU: IDLE->READ->EXEC->DONE.
// Optional op/zero counters are built when ALU_ISSUE_STATS_EN is defined.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned SIZE  = SIZE_DEFAULT,
  parameter int unsigned NREGS = 8,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_en,
  input  logic [AW-1:0]   ld_addr,
  input  logic [SIZE-1:0] ld_data,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [2:0]      instr_func,
  input  logic [AW-1:0]   instr_rs,
  input  logic [AW-1:0]   instr_rt,
  input  logic [AW-1:0]   instr_rd,
  output logic [SIZE-1:0] alu_a,
  output logic [SIZE-1:0] alu_b,
  output logic [2:0]      alu_func,
  input  logic [SIZE-1:0] alu_out,
  input  logic            alu_zero,
  output logic            done_valid,
  input  logic            done_ready,
  output logic [SIZE-1:0] done_result,
  output logic            done_zero,
  output logic [AW-1:0]   done_rd
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]     stat_ops,
  output logic [15:0]     stat_zero
`endif
);

  state_t          state_q, state_d;
  logic [2:0]      func_q;
  logic [AW-1:0]   rs_q, rt_q, rd_q;
  logic            accept;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [SIZE-1:0] wr_data;
  logic [SIZE-1:0] rdata_a, rdata_b;

  assign accept = (state_q == IDLE) && instr_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (instr_valid) state_d = READ;
      READ: state_d = EXEC;
      EXEC: state_d = DONE;
      DONE: if (done_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == IDLE);
  end

  // One write port shared by preload (IDLE only) and writeback (EXEC only);
  // a preload coinciding with accept lands before READ samples the file.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ld_addr;
    wr_data = ld_data;
    if (state_q == EXEC) begin
      wr_en   = 1'b1;
      wr_addr = rd_q;
      wr_data = alu_out;
    end else if (state_q == IDLE) begin
      wr_en   = ld_en;
    end
  end

  alu_regfile #(
    .WIDTH (SIZE),
    .DEPTH (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_en),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr_a (rs_q),
    .rdata_a (rdata_a),
    .raddr_b (rt_q),
    .rdata_b (rdata_b)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      func_q      <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_func    <= '0;
      done_valid  <= 1'b0;
      done_result <= '0;
      done_zero   <= 1'b0;
      done_rd     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            func_q <= instr_func;
            rs_q   <= instr_rs;
            rt_q   <= instr_rt;
            rd_q   <= instr_rd;
          end
        end
        READ: begin
          alu_a    <= rdata_a;
          alu_b    <= rdata_b;
          alu_func <= func_q;
        end
        EXEC: begin
          done_result <= alu_out;
          done_zero   <= alu_zero;
          done_rd     <= rd_q;
          done_valid  <= 1'b1;
        end
        DONE: begin
          if (done_ready) done_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops  <= '0;
      stat_zero <= '0;
    end else if (state_q == EXEC) begin
      stat_ops <= stat_ops + 16'd1;
      if (alu_zero) stat_zero <= stat_zero + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic [2:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_func, instr_rs, instr_rt, instr_rd;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_func;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        done_valid;
  logic        done_ready;
  logic [31:0] done_result;
  logic        done_zero;
  logic [2:0]  done_rd;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_issue_ctrl #(.SIZE(32), .NREGS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_func(instr_func), .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_rd(instr_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .done_valid(done_valid), .done_ready(done_ready),
    .done_result(done_result), .done_zero(done_zero), .done_rd(done_rd)
  );

  always_comb begin
    case (alu_func)
      FN_ADD:  alu_out = alu_a + alu_b;
      FN_SUB:  alu_out = alu_a - alu_b;
      FN_AND:  alu_out = alu_a & alu_b;
      FN_OR:   alu_out = alu_a | alu_b;
      FN_NOR:  alu_out = ~(alu_a | alu_b);
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done_valid && done_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected actual rd=%0d result=%h required=no result", done_rd, done_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_result", done_result, e.res);
        chk("done_zero", {31'd0, done_zero}, {31'd0, e.z});
        chk("done_rd", {29'd0, done_rd}, {29'd0, e.rd});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Offers an op until accepted (bounded); returns one time unit after the accept edge.
  task automatic issue(input logic [2:0] f, rs, rt, rd,
                       input logic [31:0] er, input logic ez, input bit push);
    bit accepted = 0;
    exp_t e;
    instr_valid = 1'b1; instr_func = f; instr_rs = rs; instr_rt = rt; instr_rd = rd;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (instr_ready) accepted = 1;
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
    else if (push) begin
      e.res = er; e.z = ez; e.rd = rd;
      exp_q.push_back(e);
    end
  endtask

  // Called right after the accept edge: checks ALU operands in EXEC and the 2-edge latency.
  task automatic exec_check(input logic [31:0] ea, eb, input logic [2:0] ef);
    tick();
    chk("exec_alu_a", alu_a, ea);
    chk("exec_alu_b", alu_b, eb);
    chk("exec_alu_func", {29'd0, alu_func}, {29'd0, ef});
    chk("exec_done_valid_low", {31'd0, done_valid}, 32'd0);
    tick();
    chk("latency_done_valid", {31'd0, done_valid}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || !instr_ready); i++) tick();
    chk("drain_queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    instr_valid = 1'b0; instr_func = '0; instr_rs = '0; instr_rt = '0; instr_rd = '0;
    done_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_done_valid", {31'd0, done_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_func", {29'd0, alu_func}, 32'd0);
    chk("rst_done_result", done_result, 32'd0);
    chk("rst_done_zero", {31'd0, done_zero}, 32'd0);
    chk("rst_done_rd", {29'd0, done_rd}, 32'd0);

    // SUB equal operands, r3 preloaded non-zero then overwritten with 0
    preload(3'd1, 32'd5);
    preload(3'd2, 32'd5);
    preload(3'd3, 32'd9);
    issue(FN_SUB, 3'd1, 3'd2, 3'd3, 32'd0, 1'b1, 1);
    exec_check(32'd5, 32'd5, FN_SUB);
    issue(FN_OR, 3'd3, 3'd3, 3'd6, 32'd0, 1'b1, 1);
    drain();

    // Wrapping add, then writeback visible to the next op
    preload(3'd1, 32'hFFFF_FFFF);
    preload(3'd2, 32'd1);
    issue(FN_ADD, 3'd1, 3'd2, 3'd4, 32'd0, 1'b1, 1);
    issue(FN_OR, 3'd4, 3'd2, 3'd5, 32'd1, 1'b0, 1);
    drain();

    // Back-pressure: result held, stray op not accepted
    done_ready = 1'b0;
    issue(FN_ADD, 3'd1, 3'd1, 3'd6, 32'hFFFF_FFFE, 1'b0, 1);
    tick(); tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        instr_valid = 1'b1; instr_func = FN_ADD; instr_rs = 3'd2; instr_rt = 3'd2; instr_rd = 3'd7;
      end else instr_valid = 1'b0;
      chk("hold_done_valid", {31'd0, done_valid}, 32'd1);
      chk("hold_done_result", done_result, 32'hFFFF_FFFE);
      chk("hold_instr_ready", {31'd0, instr_ready}, 32'd0);
      tick();
    end
    instr_valid = 1'b0;
    done_ready = 1'b1;
    tick(); tick();
    chk("release_instr_ready", {31'd0, instr_ready}, 32'd1);
    drain();

    // rd=0 writeback and preload discarded; undefined func gives zero
    issue(FN_ADD, 3'd6, 3'd2, 3'd0, 32'hFFFF_FFFF, 1'b0, 1);
    drain();
    preload(3'd0, 32'd123);
    issue(FN_OR, 3'd0, 3'd0, 3'd7, 32'd0, 1'b1, 1);
    issue(3'd6, 3'd1, 3'd6, 3'd5, 32'd0, 1'b1, 1);
    exec_check(32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'd6);
    issue(FN_OR, 3'd5, 3'd4, 3'd3, 32'd0, 1'b1, 1);
    drain();

    // Preload coinciding with accept; preload ignored outside IDLE
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 32'd7;
    issue(FN_ADD, 3'd1, 3'd0, 3'd2, 32'd7, 1'b0, 1);
    ld_addr = 3'd3; ld_data = 32'd99;
    exec_check(32'd7, 32'd0, FN_ADD);
    tick();
    ld_en = 1'b0;
    issue(FN_OR, 3'd3, 3'd0, 3'd4, 32'd0, 1'b1, 1);
    issue(FN_OR, 3'd2, 3'd1, 3'd4, 32'd7, 1'b0, 1);
    drain();

    // Reset mid-EXEC drops the op and clears the register file
    issue(FN_ADD, 3'd1, 3'd2, 3'd5, 32'd14, 1'b0, 0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_done_valid", {31'd0, done_valid}, 32'd0);
    chk("midrst_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("midrst_alu_a", alu_a, 32'd0);
    chk("midrst_done_result", done_result, 32'd0);
    issue(FN_OR, 3'd1, 3'd2, 3'd3, 32'd0, 1'b1, 1);
    issue(FN_OR, 3'd5, 3'd6, 3'd6, 32'd0, 1'b1, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue/writeback stage placed directly upstream of the combinational 32-bit ALU (func 0 add, 1 sub, 2 and, 3 or, 4 nor, 5-7 -> 0; zero_flag = (out==0)). Accepts register-format ops over a valid/ready handshake and reads operands from an internal 8-entry register file. Drives the ALU's a, b and func inputs, captures the ALU result and zero flag, and writes the result back. Presents each completed result on a valid/ready output.

Parameters:
SIZE, 32, datapath width; must match the ALU size parameter.
NREGS, 8, register file depth; addresses are clog2(NREGS) bits wide (3 at default).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset.
ld_en  in  1  register preload strobe; honoured only in IDLE.
ld_addr  in  3  preload address.
ld_data  in  SIZE  preload data.
instr_valid  in  1  op offered.
instr_ready  out  1  stage can accept an op.
instr_func  in  3  ALU function code.
instr_rs  in  3  source A register.
instr_rt  in  3  source B register.
instr_rd  in  3  destination register.
alu_a  out  SIZE  to ALU a.
alu_b  out  SIZE  to ALU b.
alu_func  out  3  to ALU func.
alu_out  in  SIZE  from ALU out.
alu_zero  in  1  from ALU zero_flag.
done_valid  out  1  result available.
done_ready  in  1  consumer accepts the result.
done_result  out  SIZE  captured ALU result.
done_zero  out  1  captured zero flag.
done_rd  out  3  destination that was written.

Behaviour:
- FSM states: IDLE, READ, EXEC, DONE. All state and outputs are registered.
- Reset: if rst_n=0 at a clk edge, the FSM returns to IDLE from any state, including mid-operation, and the in-flight op is dropped.
  - Reset values: all registers = 0; alu_a = alu_b = 0; alu_func = 0; done_valid = 0; done_result = 0; done_zero = 0; done_rd = 0.
  - instr_ready = 1 in the first cycle after reset.
- IDLE:
  - instr_ready = 1.
  - instr_valid & instr_ready latches func/rs/rt/rd and moves to READ.
  - ld_en writes ld_data to ld_addr in the same edge. If ld_en and an accept coincide, the load commits first and READ observes the loaded value.
- READ: alu_a <= reg[rs], alu_b <= reg[rt], alu_func <= func; go to EXEC. instr_ready = 0 and ld_en is ignored in READ, EXEC and DONE.
- EXEC: the ALU settles combinationally within this cycle. At the edge:
  - done_result <= alu_out, done_zero <= alu_zero, done_rd <= rd.
  - reg[rd] <= alu_out.
  - done_valid <= 1; go to DONE.
- DONE:
  - done_valid = 1; done_result, done_zero and done_rd are held stable until done_ready = 1.
  - On done_ready: done_valid <= 0 and go to IDLE.
- Latency: accept edge at T produces done_valid high after edge T+2. Minimum issue interval is 4 cycles when done_ready is tied high.
- Register 0 always reads 0. Writes to register 0 (ld or writeback) are discarded, but done_result still shows the ALU value.
- A following op reads the written-back value because writeback commits before IDLE.
- rs = rt = rd is legal and reads the old value.
- func 5-7 are passed through unchanged; the ALU returns 0, so done_zero = 1 and 0 is written.
- Arithmetic wraps modulo 2^SIZE; the stage adds no overflow detection.

Optional Feature:
- ALU_ISSUE_STATS_EN defined: adds two outputs.
  - stat_ops [15:0] increments on every EXEC edge.
  - stat_zero [15:0] increments on every EXEC edge where alu_zero = 1.
  - Both counters wrap at 16'hFFFF -> 0 and reset to 0.
- Undefined: neither port nor counter exists.

Decomposition:
- Shared package alu_pkg holds:
  - func code constants: FN_ADD=0, FN_SUB=1, FN_AND=2, FN_OR=3, FN_NOR=4.
  - state encoding constants: IDLE=0, READ=1, EXEC=2, DONE=3.
  - SIZE default.
- One natural sub-module: alu_regfile (2 async read ports, 1 sync write port, reg0 hardwired zero, sync active-low clear).
- The ALU is instantiated by the parent, not inside this block.

Test Plan:
- Reset mid-EXEC with rst_n=0 for one edge -> IDLE, done_valid=0, all registers 0, instr_ready=1 next cycle.
- Preload r1=5, r2=5; op SUB rs=1 rt=2 rd=3 -> done_result=0, done_zero=1, done_rd=3, done_valid two edges after accept; r3=0.
- Preload r1=32'hFFFFFFFF, r2=1; ADD rd=4 -> done_result=0, done_zero=1 (wrap). Then OR rs=4 rt=2 rd=5 -> done_result=1, done_zero=0 (writeback visible).
- Hold done_ready=0 for 5 cycles -> done_valid and done_result stable, instr_ready=0; an instr_valid pulse during this time is not accepted.
- ADD with rd=0 and func=6 -> reg0 still reads 0 on the next op; func 6 gives done_result=0, done_zero=1.
- ld_en in IDLE writes r1=7 in the same cycle an op with rs=1 is accepted -> alu_a=7; ld_en during READ/EXEC/DONE has no effect.
